// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, largest legal digit, subtractor FSM
// encoding and the digit-validity check.
package bcd_pkg;

  localparam int              DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    NEG  = 2'd3
  } state_t;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtractor: diff = a - b - bin, with a decimal borrow.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] diff,
  output logic               bout
);

  // Five bits hold the signed range -16..15; bit 4 is the sign.
  logic [DIGIT_W:0] t;

  assign t    = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
  assign bout = t[DIGIT_W];
  assign diff = t[DIGIT_W] ? t[DIGIT_W-1:0] + 4'd10 : t[DIGIT_W-1:0];

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor, one digit per clock, LSD first.
// Define BCD_SUB_SIGNMAG_EN to return sign-magnitude instead of ten's complement.
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   bin,
  input  logic [4*NDIGITS-1:0]   a,
  input  logic [4*NDIGITS-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   diff,
  output logic                   bout,
  output logic                   invalid
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIGITS - 1);

  state_t state, state_next;

  logic [NDIGITS-1:0][DIGIT_W-1:0] wa, wb, wr, wr_next;
  logic [IDX_W-1:0]                idx;
  logic                            borrow, inv_w, start_inv, last;
  logic [DIGIT_W-1:0]              op_a, op_b, sub_diff;
  logic                            sub_bout;

  assign last = (idx == LAST);
  assign busy = (state == RUN) || (state == NEG);
  assign done = (state == DONE);

  bcd_digit_sub u_digit (
    .a    (op_a),
    .b    (op_b),
    .bin  (borrow),
    .diff (sub_diff),
    .bout (sub_bout)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    start_inv = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      start_inv = start_inv | digit_invalid(a[i*DIGIT_W +: DIGIT_W])
                            | digit_invalid(b[i*DIGIT_W +: DIGIT_W]);
    end
  end

  always_comb begin
    op_a = wa[idx];
    op_b = wb[idx];
`ifdef BCD_SUB_SIGNMAG_EN
    if (state == NEG) begin
      op_a = '0;
      op_b = wr[idx];
    end
`endif
    wr_next      = wr;
    wr_next[idx] = sub_diff;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (last) begin
`ifdef BCD_SUB_SIGNMAG_EN
          state_next = sub_bout ? NEG : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef BCD_SUB_SIGNMAG_EN
      NEG:  if (last) state_next = DONE;
`endif
      DONE: state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the working registers are reset too; they are few and it keeps reset state fully known.
  always_ff @(posedge clk) begin
    if (rst) begin
      wa      <= '0;
      wb      <= '0;
      wr      <= '0;
      idx     <= '0;
      borrow  <= 1'b0;
      inv_w   <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            wa     <= a;
            wb     <= b;
            borrow <= bin;
            inv_w  <= start_inv;
            idx    <= '0;
          end
        end
        RUN: begin
          wr     <= wr_next;
          borrow <= sub_bout;
          idx    <= last ? '0 : idx + 1'b1;
          if (last) begin
`ifdef BCD_SUB_SIGNMAG_EN
            // Negative: keep the result internal and negate it in NEG first.
            if (sub_bout) begin
              borrow <= 1'b0;
            end else begin
              diff    <= wr_next;
              bout    <= 1'b0;
              invalid <= inv_w;
            end
`else
            diff    <= wr_next;
            bout    <= sub_bout;
            invalid <= inv_w;
`endif
          end
        end
`ifdef BCD_SUB_SIGNMAG_EN
        NEG: begin
          wr     <= wr_next;
          borrow <= sub_bout;
          idx    <= last ? '0 : idx + 1'b1;
          if (last) begin
            diff    <= wr_next;
            bout    <= 1'b1;
            invalid <= inv_w;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Self-checking bench for bcd_sub_serial against a decimal-integer reference model.
// Honours BCD_SUB_SIGNMAG_EN for the sign-magnitude expectations.
module tb_bcd_sub_serial;

  localparam int N = 4;
  localparam int W = 4 * N;
  localparam int MAX_WAIT = 60;

  logic         clk = 1'b0;
  logic         rst, start, bin;
  logic [W-1:0] a, b, diff;
  logic         busy, done, bout, invalid;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  bcd_sub_serial #(.NDIGITS(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin     (bin),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .bout    (bout),
    .invalid (invalid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] x, input logic [W-1:0] y);
    logic bad = 1'b0;
    for (int i = 0; i < N; i++)
      if (x[i*4 +: 4] > 4'd9 || y[i*4 +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] ed, output logic eb, output int elat);
    int r;
    r = bcd2int(ma) - bcd2int(mb) - int'(mbin);
    if (r >= 0) begin
      ed = int2bcd(r); eb = 1'b0; elat = N + 1;
    end else begin
`ifdef BCD_SUB_SIGNMAG_EN
      ed = int2bcd(-r); eb = 1'b1; elat = 2 * N + 1;
`else
      ed = int2bcd(r + 10 ** N); eb = 1'b1; elat = N + 1;
`endif
    end
  endtask

  // Issue one operation, wait for done and check everything the model predicts.
  task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic obin);
    logic [W-1:0] ed;
    logic         eb, einv;
    int           elat, lat;
    model(oa, ob, obin, ed, eb, elat);
    einv = has_bad_digit(oa, ob);
    a = oa; b = ob; bin = obin; start = 1'b1;
    tick();
    lat = 1;
    start = 1'b0;
    check({tag, "/busy"}, 64'(busy), 64'(1));
    while (!done && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    check({tag, "/invalid"}, 64'(invalid), 64'(einv));
    if (!einv) begin
      check({tag, "/latency"}, 64'(lat), 64'(elat));
      check({tag, "/diff"}, 64'(diff), 64'(ed));
      check({tag, "/bout"}, 64'(bout), 64'(eb));
    end else begin
      check({tag, "/done_seen"}, 64'(done), 64'(1));
    end
    tick();
    check({tag, "/done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int lat, seen;
    logic [W-1:0] ed;
    logic eb;
    int elat;

    rst = 1'b1; start = 1'b0; bin = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("rst/busy", 64'(busy), 64'(0));
    check("rst/done", 64'(done), 64'(0));
    check("rst/diff", 64'(diff), 64'(0));
    check("rst/bout", 64'(bout), 64'(0));
    check("rst/invalid", 64'(invalid), 64'(0));
    rst = 1'b0;
    tick();

    do_op("pos", 16'h5678, 16'h1234, 1'b0);
    do_op("neg", 16'h1234, 16'h5678, 1'b0);
    do_op("borrow_chain", 16'h1000, 16'h0001, 1'b0);
    do_op("zero_bin", 16'h0000, 16'h0000, 1'b1);

    // Start pulses while busy are ignored; a start in the DONE cycle is accepted.
    a = 16'h5678; b = 16'h1234; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'h1111; b = 16'h9999; bin = 1'b1; start = 1'b1;
    tick();
    tick();
    tick();
    check("ignore/done", 64'(done), 64'(1));
    check("ignore/diff", 64'(diff), 64'(16'h4444));
    check("ignore/bout", 64'(bout), 64'(0));
    a = 16'h9000; b = 16'h0123; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b/busy", 64'(busy), 64'(1));
    lat = 1;
    while (!done && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    model(16'h9000, 16'h0123, 1'b0, ed, eb, elat);
    check("b2b/latency", 64'(lat), 64'(elat));
    check("b2b/diff", 64'(diff), 64'(ed));
    tick();

    // Reset in cycle 3 aborts the operation.
    a = 16'h5678; b = 16'h1234; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort/busy", 64'(busy), 64'(0));
    check("abort/done", 64'(done), 64'(0));
    check("abort/diff", 64'(diff), 64'(0));
    check("abort/bout", 64'(bout), 64'(0));
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) seen++;
    end
    check("abort/no_done", 64'(seen), 64'(0));

    do_op("invalid", 16'h000A, 16'h0001, 1'b0);
    do_op("valid_after", 16'h1111, 16'h0111, 1'b0);

    for (int k = 0; k < 20; k++) begin
      do_op($sformatf("rand%0d", k), rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_sub_serial.md
Name: bcd_sub_serial

Overview:
- Digit-serial multi-digit BCD subtractor; the inverse operation of the team's 4-digit BCD adder.
- Computes A - B - bin on packed BCD operands, one digit per clock, least significant digit first.
- Uses a start/busy/done handshake and a registered result.
- Sits beside the BCD adder in the arithmetic datapath; a controller issues subtract requests to it.

Parameters:
- NDIGITS, 4, number of BCD digits per operand (each digit 4 bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active high.
- start  input  1  request; sampled only when busy=0.
- bin  input  1  borrow-in, latched with start.
- a  input  4*NDIGITS  minuend, packed BCD, digit 0 in [3:0].
- b  input  4*NDIGITS  subtrahend, packed BCD.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- diff  output  4*NDIGITS  registered BCD difference.
- bout  output  1  registered final borrow (1 = result negative).
- invalid  output  1  registered; 1 if any latched digit of a or b exceeded 9.

Behaviour:
- Reset values: busy=0, done=0, diff=0, bout=0, invalid=0, state=IDLE, digit index=0.
- Reset has priority over every other event. Asserting rst mid-operation aborts the operation, discards partial results, and returns the block to IDLE.
- FSM states: IDLE, RUN, DONE (NEG only when the optional feature is built).
- IDLE:
  - start=1 latches a, b and bin into working registers and sets the working borrow to bin.
  - invalid is computed from the latched operands.
  - Index is set to 0; transition to RUN.
- RUN, once per cycle:
  - Digit op: t = a[i] - b[i] - borrow, computed 5-bit signed.
  - If t<0: digit = t+10 and borrow=1; otherwise digit = t and borrow=0.
  - Store the digit in the working result and increment the index.
  - After digit NDIGITS-1: copy the working result to diff, set bout = final borrow, go to DONE.
- DONE: done=1 for exactly this cycle, busy=0, then return to IDLE.
  - start asserted in the DONE cycle is accepted exactly as in IDLE.
- busy=1 in RUN and NEG. start while busy=1 is ignored, with no queueing.
- Latency: start high in cycle 0 puts done high in cycle NDIGITS+1 (cycle 5 for the default).
- diff, bout and invalid hold their values from done until the next completion or reset. They never show partial values.
- Negative results in the default build are ten's complement: 0000-0001 gives diff=9999, bout=1.
- Invalid digits (>9): the arithmetic still runs but the resulting digit values are don't-care; only invalid=1 is guaranteed.
- The index wraps to 0 on every new start. There is no state in which it can exceed NDIGITS-1.

Optional Feature:
- Macro: BCD_SUB_SIGNMAG_EN.
- Defined:
  - When the final borrow is 1, RUN goes to NEG instead of DONE.
  - NEG runs NDIGITS more cycles computing 0 - working_result digit-serially with borrow-in 0, giving the magnitude.
  - diff = magnitude, bout = 1 (sign), then DONE.
  - Latency for negative results is 2*NDIGITS+1; positive results are unchanged.
- Undefined: NEG does not exist and results are ten's complement as above.

Decomposition:
- Package bcd_pkg holds:
  - DIGIT_W=4 and BCD_MAX=9.
  - The state encoding (IDLE, RUN, DONE, NEG).
  - A digit-invalid check function.
- Sub-module bcd_digit_sub: combinational, ports a[3:0], b[3:0], bin → diff[3:0], bout. It is shared by the RUN and NEG paths.

Test Plan:
- a=5678, b=1234, bin=0 → done in cycle 5, diff=4444, bout=0, invalid=0.
- a=1234, b=5678, bin=0:
  - default build → diff=5556, bout=1.
  - with BCD_SUB_SIGNMAG_EN → diff=4444, bout=1, done in cycle 9.
- a=1000, b=0001 → diff=0999, bout=0. Separately, a=0000, b=0000, bin=1 → diff=9999, bout=1.
- Pulse start again in cycles 2–4 with different operands → ignored; the result is still for the first operands. Then start in the DONE cycle → accepted, with a second done 5 cycles later.
- rst in cycle 3 of an operation → next cycle busy=0, done=0, diff=0, bout=0, and no done pulse follows.
- a=000A, b=0001 → invalid=1 at done. A following valid operation returns invalid to 0.
